// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_pkg                                                   |
// | Purpose  : Shared command/state encodings and frame helpers for the  |
// |            SPI master, the spi_wrapper slave and system benches.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int FRAME_W = 11;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    RECV = 2'b10,
    GAP  = 2'b11
  } state_e;

  // The slave decodes a 3-bit opcode; the top command bit is sent twice.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] t,
                                                     input logic [DATA_W-1:0] d);
    return {t[1], t, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_master_shifter                                        |
// | Purpose  : 11-bit PISO for MOSI and 8-bit SIPO for MISO.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic               capture,
  input  logic [FRAME_W-1:0] frame,
  input  logic               miso,
  output logic               mosi,
  output logic [DATA_W-1:0]  rx_word
);

  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;

  // Zeros are shifted in behind the frame so MOSI idles low once the
  // last bit has been presented.
  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load) begin
      tx_d = frame;
    end else if (shift) begin
      tx_d = {tx_q[FRAME_W-2:0], 1'b0};
    end
    if (capture) begin
      rx_d = {rx_q[DATA_W-2:0], miso};
    end
  end

  // Shift registers; MOSI comes straight off the top flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign mosi    = tx_q[FRAME_W-1];
  assign rx_word = rx_q;

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_master                                                |
// | Purpose  : Host-side SPI initiator; one command per handshake,       |
// |            11-bit MSB-first frame, 8-bit reply for RD_DATA.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned MISO_GAP    = 0,
  parameter int unsigned IDLE_CYCLES = 2
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              MOSI,
  output logic              SS_n,
  input  logic              MISO
);

  localparam logic [3:0] LAST_TX_BIT = 4'(FRAME_W - 1);
  localparam logic [3:0] LAST_RX_BIT = 4'(DATA_W - 1);
  localparam logic [3:0] RX_DONE     = 4'(DATA_W);
  localparam logic [3:0] MISO_WAIT   = 4'(MISO_GAP);
  // The IDLE cycle itself is one of the SS_n-high cycles, so GAP is one shorter.
  localparam logic [3:0] GAP_RELOAD  = 4'(IDLE_CYCLES - 1);
  localparam bit         HAS_GAP     = (IDLE_CYCLES > 1);

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       ss_n_q, ss_n_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_cmd_q, rd_cmd_d;

  logic              accept;
  logic              load, shift, capture;
  logic [DATA_W-1:0] rx_word;

  assign accept = cmd_valid && cmd_ready_q;

  // Frame sequencing: next state, counters, select and handshake.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ss_n_d     = ss_n_q;
    rd_cmd_d   = rd_cmd_q;
    rd_valid_d = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        if (accept) begin
          load      = 1'b1;
          state_d   = SEND;
          bit_cnt_d = 4'd0;
          ss_n_d    = 1'b0;
          rd_cmd_d  = (cmd_type == RD_DATA);
        end
      end
      SEND: begin
        shift = 1'b1;
        if (bit_cnt_q == LAST_TX_BIT) begin
          bit_cnt_d = 4'd0;
          if (rd_cmd_q) begin
            state_d   = RECV;
            gap_cnt_d = MISO_WAIT;
          end else begin
            ss_n_d    = 1'b1;
            gap_cnt_d = GAP_RELOAD;
            state_d   = HAS_GAP ? GAP : IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      RECV: begin
        // One trailing select-low cycle follows the last sample.
        if (bit_cnt_q == RX_DONE) begin
          ss_n_d    = 1'b1;
          gap_cnt_d = GAP_RELOAD;
          state_d   = HAS_GAP ? GAP : IDLE;
        end else if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else begin
          capture   = 1'b1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_RX_BIT) begin
            rd_valid_d = 1'b1;
          end
        end
      end
      GAP: begin
        ss_n_d = 1'b1;
        if (gap_cnt_q <= 4'd1) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // Control registers; reset aborts any frame and raises SS_n at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      gap_cnt_q   <= 4'd0;
      ss_n_q      <= 1'b1;
      cmd_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_cmd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ss_n_q      <= ss_n_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_cmd_q    <= rd_cmd_d;
    end
  end

  spi_master_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .shift   (shift),
    .capture (capture),
    .frame   (build_frame(cmd_type, cmd_data)),
    .miso    (MISO),
    .mosi    (MOSI),
    .rx_word (rx_word)
  );

  assign SS_n      = ss_n_q;
  assign cmd_ready = cmd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rx_word;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_spi_master                                             |
// | Purpose  : Directed self-checking bench for spi_master with a        |
// |            behavioural SPI+RAM slave model.                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;

  int n_checks = 0;
  int n_pass   = 0;

  spi_master #(.MISO_GAP(0), .IDLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .MOSI      (MOSI),
    .SS_n      (SS_n),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  // Slave model and line monitor state
  int          low_cnt = 0;
  int          high_cnt = 0;
  logic [10:0] bits = '0;
  logic [10:0] frames_q[$];
  int          lows_q[$];
  int          highs_q[$];
  int          rv_cnt = 0;
  int          rv_pos = -1;
  logic [7:0]  rv_data = '0;
  int          ready_err = 0;
  int          busy_err = 0;
  logic        cur_rd = 1'b0;
  logic [7:0]  ram [256];
  logic [7:0]  wa = '0;
  logic [7:0]  ra = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Monitor: observes the bus on falling edges and plays the slave.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      rv_cnt++;
      rv_data = rd_data;
      rv_pos  = (SS_n === 1'b0) ? low_cnt : -1;
    end
    if (SS_n === 1'b0) begin
      if (low_cnt == 0) begin
        highs_q.push_back(high_cnt);
        high_cnt = 0;
      end
      if (cmd_ready === 1'b1) ready_err++;
      if (busy !== 1'b1) busy_err++;
      if (low_cnt < 11) bits = {bits[9:0], MOSI};
      if (low_cnt == 10) begin
        case (bits[9:8])
          2'b00: wa = bits[7:0];
          2'b01: ram[wa] = bits[7:0];
          2'b10: ra = bits[7:0];
          default: cur_rd = 1'b1;
        endcase
      end
      if (cur_rd && low_cnt >= 11 && low_cnt <= 18) MISO = ram[ra][18-low_cnt];
      else MISO = 1'($urandom);
      low_cnt++;
    end else begin
      if (low_cnt != 0) begin
        frames_q.push_back(bits);
        lows_q.push_back(low_cnt);
        low_cnt = 0;
        cur_rd  = 1'b0;
      end
      high_cnt++;
      MISO = 1'($urandom);
    end
  end

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] d);
    wait_ready(200);
    cmd_type  = t;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic clear_logs();
    frames_q.delete();
    lows_q.delete();
    highs_q.delete();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ta [4];
    logic [7:0] td [4];
    int rv0;
    ta = '{8'h10, 8'h20, 8'hF0, 8'hFF};
    td = '{8'h01, 8'h80, 8'h7F, 8'hC3};
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_data = 8'h00; MISO = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss_n", SS_n, 1'b1);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_rst", cmd_ready, 1'b1);

    // WR_ADDR 0x3C
    clear_logs();
    send(2'b00, 8'h3C);
    wait_ready(200);
    check("t1_nframes", frames_q.size(), 1);
    check("t1_frame", frames_q[0], 11'h03C);
    check("t1_low", lows_q[0], 11);
    check("t1_no_rv", rv_cnt, 0);

    // WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA
    clear_logs();
    send(2'b01, 8'hA5);
    send(2'b10, 8'h3C);
    send(2'b11, 8'h5A);
    wait_ready(200);
    check("t2_frame_wd", frames_q[0], 11'h1A5);
    check("t2_frame_ra", frames_q[1], 11'h63C);
    check("t2_frame_rd", frames_q[2], 11'h75A);
    check("t2_low_wd", lows_q[0], 11);
    check("t2_low_rd", lows_q[2], 20);
    check("t2_rv_cnt", rv_cnt, 1);
    check("t2_rv_data", rv_data, 8'hA5);
    check("t2_rv_pos", rv_pos, 19);
    check("t2_rd_data_hold", rd_data, 8'hA5);

    // Back-to-back with cmd_valid held high
    clear_logs();
    wait_ready(200);
    cmd_type = 2'b01; cmd_data = 8'h11; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) wait_ready(200);
      @(posedge clk);
      #1 cmd_data = cmd_data + 8'h11;
    end
    cmd_valid = 1'b0;
    wait_ready(200);
    check("t3_nframes", frames_q.size(), 3);
    check("t3_frame0", frames_q[0], 11'h111);
    check("t3_frame1", frames_q[1], 11'h122);
    check("t3_frame2", frames_q[2], 11'h133);
    check("t3_gap1", highs_q[1], 2);
    check("t3_gap2", highs_q[2], 2);
    check("ready_low_in_frame", ready_err, 0);
    check("busy_in_frame", busy_err, 0);

    // Reset at bit 5 of a RD_DATA frame
    rv0 = rv_cnt;
    wait_ready(200);
    cmd_type = 2'b11; cmd_data = 8'h00; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t4_ss_n_async", SS_n, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_mosi", MOSI, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t4_no_rv", rv_cnt, rv0);
    clear_logs();
    send(2'b00, 8'h55);
    wait_ready(200);
    check("t4_clean_frame", frames_q[0], 11'h055);
    check("t4_clean_low", lows_q[0], 11);

    // Command inputs change during SEND
    clear_logs();
    wait_ready(200);
    cmd_type = 2'b00; cmd_data = 8'h81; cmd_valid = 1'b1;
    @(posedge clk);
    #1 begin cmd_type = 2'b10; cmd_data = 8'h7E; end
    wait_ready(200);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_ready(200);
    check("t5_nframes", frames_q.size(), 2);
    check("t5_frame0", frames_q[0], 11'h081);
    check("t5_frame1", frames_q[1], 11'h67E);
    check("t5_gap", highs_q[1], 2);

    // RAM write/read-back table
    for (int i = 0; i < 4; i++) begin
      send(2'b00, ta[i]);
      send(2'b01, td[i]);
    end
    for (int i = 3; i >= 0; i--) begin
      send(2'b10, ta[i]);
      send(2'b11, 8'h00);
      wait_ready(200);
      check("t6_rv_data", rv_data, td[i]);
      check("t6_rd_data", rd_data, td[i]);
    end
    check("t6_rv_cnt", rv_cnt, rv0 + 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
